// File: rtl/latency_meter_pkg.sv
// Shared types and constants for the photo-sensor latency meter.
package latency_meter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StMeasure,
    StRelease
  } state_e;

  localparam logic [7:0] NSamplesRst = 8'd0;
  localparam logic [7:0] NSamplesMax = 8'd255;

  // Cycles of fixed pipeline delay that are included in every reported latency.
  function automatic int unsigned lat_offset(input int unsigned sync_stages,
                                             input int unsigned debounce_cyc);
    return sync_stages + debounce_cyc;
  endfunction

endpackage

// File: rtl/latency_meter_sensor_debounce.sv
// Sensor input synchroniser followed by a stable-level debounce counter.
module sensor_debounce #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = 64
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic raw_i,
  output logic level_o
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DbW-1:0]         db_cnt_q;
  logic                   level_q;
  logic                   synced;

  assign synced  = sync_q[SYNC_STAGES-1];
  assign level_o = level_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q   <= '0;
      db_cnt_q <= '0;
      level_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
      if (synced == level_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DbLast) begin
        // Counter reaches DEBOUNCE_CYC on this cycle: commit the new level.
        level_q  <= ~level_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + DbW'(1);
      end
    end
  end

endmodule

// File: rtl/latency_meter.sv
// Measures cycles from stimulus start to debounced sensor assertion and keeps running stats.
module latency_meter
  import latency_meter_pkg::*;
#(
  parameter int unsigned CNT_W          = 24,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned DEBOUNCE_CYC   = 64,
  parameter int unsigned TIMEOUT_CYC    = 8000000,
  parameter int unsigned SENSOR_BIT     = 0,
  parameter bit          SENSOR_ACT_LOW = 1'b1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             arm_i,
  input  logic             stim_start_i,
  input  logic             clear_stats_i,
  input  logic [6:0]       user_in_i,
  output logic [6:0]       user_out_o,
  output logic             busy_o,
  output logic             sensor_level_o,
  output logic             result_valid_o,
  output logic [CNT_W-1:0] result_o,
  output logic             timeout_o,
  output logic             stuck_o,
  output logic [7:0]       n_samples_o,
  output logic [CNT_W-1:0] lat_min_o,
  output logic [CNT_W-1:0] lat_max_o,
  output logic [CNT_W+7:0] lat_sum_o
);

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT_CYC);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q, cnt_inc, result_q;
  logic             result_valid_q, timeout_q, stuck_q;
  logic [7:0]       n_q;
  logic [CNT_W-1:0] min_q, max_q;
  logic [CNT_W+7:0] sum_q;
  logic             sensor_raw, sensor_level, hit_timeout, sample_ok;
  logic             unused_user_in;

  assign sensor_raw     = user_in_i[SENSOR_BIT] ^ SENSOR_ACT_LOW;
  assign unused_user_in = ^user_in_i;

  sensor_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_sensor_debounce (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .raw_i  (sensor_raw),
    .level_o(sensor_level)
  );

  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign hit_timeout = (cnt_inc == TimeoutVal);
  assign sample_ok   = (state_q == StMeasure) && sensor_level;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
      timeout_q      <= 1'b0;
      stuck_q        <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: if (arm_i) state_q <= StArmed;
        StArmed: begin
          if (stim_start_i && sensor_level) begin
            stuck_q        <= 1'b1;
            timeout_q      <= 1'b0;
            result_valid_q <= 1'b1;
            state_q        <= StIdle;
          end else if (stim_start_i) begin
            cnt_q   <= '0;
            state_q <= StMeasure;
          end
        end
        StMeasure: begin
          if (sensor_level) begin
            result_q       <= cnt_inc;
            timeout_q      <= 1'b0;
            stuck_q        <= 1'b0;
            result_valid_q <= 1'b1;
            cnt_q          <= '0;
            state_q        <= StRelease;
          end else if (hit_timeout) begin
            result_q       <= '1;
            timeout_q      <= 1'b1;
            stuck_q        <= 1'b0;
            result_valid_q <= 1'b1;
            state_q        <= StIdle;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StRelease: begin
          // Sensor stuck asserted after a sample: give up silently, flag only.
          if (!sensor_level) begin
            state_q <= StIdle;
          end else if (hit_timeout) begin
            timeout_q <= 1'b1;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_stats_i) begin
      n_q   <= NSamplesRst;
      min_q <= '1;
      max_q <= '0;
      sum_q <= '0;
    end else if (sample_ok && (n_q != NSamplesMax)) begin
      n_q   <= n_q + 8'd1;
      sum_q <= sum_q + (CNT_W + 8)'(cnt_inc);
      if (cnt_inc < min_q) min_q <= cnt_inc;
      if (cnt_inc > max_q) max_q <= cnt_inc;
    end
  end

  assign user_out_o     = 7'h7F;
  assign busy_o         = (state_q != StIdle);
  assign sensor_level_o = sensor_level;
  assign result_valid_o = result_valid_q;
  assign result_o       = result_q;
  assign timeout_o      = timeout_q;
  assign stuck_o        = stuck_q;
  assign n_samples_o    = n_q;
  assign lat_min_o      = min_q;
  assign lat_max_o      = max_q;
  assign lat_sum_o      = sum_q;

endmodule
